buf_cnt_ctrl: RTL and testbench

BUF_CNT_CTRL -- requirements
Module: buf_cnt_ctrl

---
 rtl/buf_cnt_ctrl.sv | 118 +++++++++++
 tb/tb_buf_cnt_ctrl.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/buf_cnt_ctrl.sv
// Control FSM for a load-and-count buffer/counter datapath with run-length tracking.
// Optional RUN-state timeout is compiled in with `define BUF_CNT_CTRL_TIMEOUT_EN.
module buf_cnt_ctrl #(
  parameter int unsigned CW      = 8,
  parameter int unsigned TIMEOUT = 200
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          pause,
  input  logic          abort,
  input  logic          co,
  output logic          ld,
  output logic          ci,
  output logic          en_cnt,
  output logic          en_tri,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [CW-1:0] run_len
);

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10,
    StDone = 2'b11
  } state_e;

  state_e        state_q, state_d;
  logic          err_q, err_d;
  logic [CW-1:0] len_q, len_d;
  logic          tmo_hit;

`ifdef BUF_CNT_CTRL_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  logic [TW-1:0] tmo_q, tmo_d;

  // Counts RUN cycles including paused ones; restarts on every entry to RUN.
  always_comb begin
    tmo_d = '0;
    if (state_q == StRun) tmo_d = tmo_q + 1'b1;
  end

  assign tmo_hit = (tmo_q == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) tmo_q <= '0;
    else      tmo_q <= tmo_d;
  end
`else
  assign tmo_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    len_d   = len_q;
    ld      = 1'b0;
    ci      = 1'b0;
    en_cnt  = 1'b0;
    en_tri  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StLoad;
          len_d   = '0;
          err_d   = 1'b0;
        end
      end
      StLoad: begin
        ld      = 1'b1;
        busy    = 1'b1;
        state_d = abort ? StIdle : StRun;
      end
      StRun: begin
        busy   = 1'b1;
        en_tri = 1'b1;
        en_cnt = !pause;
        ci     = !pause;
        if (!pause && (len_q != '1)) len_d = len_q + 1'b1;
        // co beats abort and timeout; abort beats timeout.
        if (co) begin
          state_d = StDone;
        end else if (abort) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end else if (tmo_hit) begin
          state_d = StDone;
          err_d   = 1'b1;
        end
      end
      StDone: begin
        done    = 1'b1;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      len_q   <= len_d;
    end
  end

  assign err     = err_q;
  assign run_len = len_q;

endmodule

// File: tb/tb_buf_cnt_ctrl.sv
// Scoreboard bench for buf_cnt_ctrl: expected transaction outcomes are queued at
// stimulus time and compared when the FSM returns to idle.
module tb_buf_cnt_ctrl;

  localparam int unsigned CW = 8;
  localparam int unsigned TO = 10;
`ifdef BUF_CNT_CTRL_TIMEOUT_EN
  localparam bit TmoEn = 1'b1;
`else
  localparam bit TmoEn = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst, start, pause, abort, co;
  logic          ld, ci, en_cnt, en_tri, busy, done, err;
  logic [CW-1:0] run_len;

  typedef struct packed {
    logic          dn;
    logic          er;
    logic [CW-1:0] len;
  } exp_t;

  exp_t sb_q[$];
  int   n_chk = 0;
  int   n_err = 0;

  buf_cnt_ctrl #(.CW(CW), .TIMEOUT(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .pause  (pause),
    .abort  (abort),
    .co     (co),
    .ld     (ld),
    .ci     (ci),
    .en_cnt (en_cnt),
    .en_tri (en_tri),
    .busy   (busy),
    .done   (done),
    .err    (err),
    .run_len(run_len)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One transaction from IDLE. co_cyc/ab_cyc are RUN cycle numbers (0 = never);
  // pmask bit k-1 pauses RUN cycle k.
  task automatic run_txn(input int co_cyc, input int ab_cyc, input logic [15:0] pmask,
                         input bit hold);
    exp_t e;
    int   len = 0;
    bit   fin = 0;
    bit   idle = 0;
    bit   dn_seen = 0;
    start = 1'b1;
    @(posedge clk); #1;
    if (!hold) start = 1'b0;
    @(negedge clk);
    check_eq("load_ld", ld, 1);
    check_eq("load_en_tri", en_tri, 0);
    @(posedge clk); #1;
    for (int k = 1; k <= 400 && !fin; k++) begin
      pause = (k <= 16) ? pmask[k-1] : 1'b0;
      co    = (k == co_cyc);
      abort = (k == ab_cyc);
      @(negedge clk);
      check_eq("run_en_cnt", en_cnt, !pause);
      if (k == 1) check_eq("run_en_tri", en_tri, 1);
      if (!pause && len < (2 ** CW - 1)) len++;
      if (co) begin
        fin = 1; e.dn = 1'b1; e.er = 1'b0;
      end else if (abort) begin
        fin = 1; e.dn = 1'b0; e.er = 1'b1;
      end else if (TmoEn && k == TO) begin
        fin = 1; e.dn = 1'b1; e.er = 1'b1;
      end
      @(posedge clk); #1;
    end
    co = 1'b0; abort = 1'b0; pause = 1'b0;
    if (!fin) check_eq("run_no_exit", 0, 1);
    e.len = CW'(len);
    sb_q.push_back(e);
    for (int c = 0; c < 4 && !idle; c++) begin
      @(negedge clk);
      if (done) dn_seen = 1;
      if (done) check_eq("done_en_tri", en_tri, 0);
      if (!busy && !done) idle = 1;
      else begin @(posedge clk); #1; end
    end
    if (!idle) check_eq("idle_wait", 0, 1);
    check_eq("idle_ld", ld, 0);
    e = sb_q.pop_front();
    check_eq("txn_done", dn_seen, e.dn);
    check_eq("txn_err", err, e.er);
    check_eq("txn_len", run_len, e.len);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; start = 1'b0; pause = 1'b0; abort = 1'b0; co = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_outs", {ld, ci, en_cnt, en_tri, busy, done, err}, 0);
    check_eq("rst_len", run_len, 0);
    rst = 1'b1;
    @(negedge clk);
    check_eq("post_rst_busy", busy, 0);

    run_txn(6, 0, 16'h0000, 0);   // plain count, len 6
    run_txn(6, 0, 16'h0006, 0);   // paused RUN cycles 2-3, len 4
    run_txn(0, 3, 16'h0000, 0);   // abort -> err, no done
    run_txn(4, 4, 16'h0000, 0);   // co beats abort, err cleared
    run_txn(3, 0, 16'h0001, 1);   // start held: back-to-back
    run_txn(2, 0, 16'h0000, 0);

    // Asynchronous reset between edges in the middle of RUN.
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    #1;
    check_eq("pre_rst_en_tri", en_tri, 1);
    rst = 1'b0;
    #1;
    check_eq("async_en_tri", en_tri, 0);
    check_eq("async_busy", busy, 0);
    check_eq("async_len", run_len, 0);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_eq("after_rst_done", done, 0);
    check_eq("after_rst_busy", busy, 0);
    run_txn(5, 0, 16'h0010, 0);   // resumes normally, len 4

    if (TmoEn) run_txn(0, 0, 16'h0003, 0);  // times out after 10 RUN cycles, len 8
    else       run_txn(300, 0, 16'h0000, 0); // long run saturates run_len at 255

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
